// File: rtl/aes_host_sequencer.sv
// Byte-serial host front-end for the AES-128 core: loads key/plaintext, pulses the core buttons,
// waits for done and streams the ciphertext back. Optional watchdog: define AES_SEQ_TIMEOUT_EN.
module aes_host_sequencer #(
  parameter int BTN_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_byte,
  output logic [127:0] key,
  output logic [127:0] plain_text,
  output logic         entr_new_pair_btn,
  output logic         strt_btn,
  input  logic         done,
  input  logic [127:0] cipher_text,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {
    LOAD_KEY, LOAD_PT, NEWPAIR, START, WAIT_DONE, UNLOAD
  } state_e;

  localparam logic [3:0] BTN_LAST = 4'(BTN_CYCLES - 1);

  if (BTN_CYCLES < 1 || BTN_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("aes_host_sequencer: BTN_CYCLES must be 1..15 and TIMEOUT_CYCLES >= 1");
  end

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] key_q, key_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] shift_q, shift_d;
  logic         done_q;
  logic         done_rise;
  logic         tmo_hit;

  // done_q tracks done every cycle so a level already high on WAIT_DONE entry is not an edge
  assign done_rise = done && !done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    pt_d    = pt_q;
    shift_d = shift_q;
    unique case (state_q)
      LOAD_KEY: if (in_valid) begin
        key_d = {key_q[119:0], in_byte};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          cnt_d   = 4'd0;
          state_d = LOAD_PT;
        end
      end
      LOAD_PT: if (in_valid) begin
        pt_d  = {pt_q[119:0], in_byte};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          cnt_d   = 4'd0;
          state_d = NEWPAIR;
        end
      end
      NEWPAIR: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == BTN_LAST) begin
          cnt_d   = 4'd0;
          state_d = START;
        end
      end
      START: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == BTN_LAST) begin
          cnt_d   = 4'd0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done_rise) begin
          shift_d = cipher_text;
          state_d = UNLOAD;
        end else if (tmo_hit) begin
          state_d = LOAD_KEY;
        end
      end
      UNLOAD: if (out_ready) begin
        shift_d = {shift_q[119:0], 8'h00};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          cnt_d   = 4'd0;
          state_d = LOAD_KEY;
        end
      end
      default: state_d = LOAD_KEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD_KEY;
      cnt_q   <= 4'd0;
      key_q   <= '0;
      pt_q    <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      shift_q <= shift_d;
      done_q  <= done;
    end
  end

`ifdef AES_SEQ_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        err_q, err_d;

  // counts WAIT_DONE cycles; any other state holds it at zero so each entry starts fresh
  always_comb begin
    tmo_d = (state_q == WAIT_DONE) ? tmo_q + 32'd1 : 32'd0;
    err_d = err_q | tmo_hit;
  end

  assign tmo_hit = (state_q == WAIT_DONE) && !done_rise &&
                   (tmo_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  assign in_ready          = (state_q == LOAD_KEY) || (state_q == LOAD_PT);
  assign busy              = !in_ready;
  assign out_valid         = (state_q == UNLOAD);
  assign out_byte          = shift_q[127:120];
  assign entr_new_pair_btn = (state_q == NEWPAIR);
  assign strt_btn          = (state_q == START);
  assign key               = key_q;
  assign plain_text        = pt_q;

endmodule

// File: tb/tb_aes_host_sequencer.sv
// Self-checking bench for aes_host_sequencer; models the AES core's done/cipher_text handshake.
module tb_aes_host_sequencer;
  localparam int BTN = 2;
`ifdef AES_SEQ_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 4096;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_byte = 8'h00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_byte;
  logic [127:0] key, plain_text;
  logic         np_btn, st_btn;
  logic         done = 1'b0;
  logic [127:0] cipher_text = '0;
  logic         busy, err;

  int n_chk  = 0;
  int n_pass = 0;

  aes_host_sequencer #(.BTN_CYCLES(BTN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .key(key), .plain_text(plain_text),
    .entr_new_pair_btn(np_btn), .strt_btn(st_btn),
    .done(done), .cipher_text(cipher_text),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offers bytes MSB-first; a handshake is counted when valid is offered in a cycle with in_ready high.
  task automatic send_bytes(input logic [255:0] blk, input int nbytes, input bit stall,
                            output int nhs, output int ncyc);
    int i = 0;
    nhs  = 0;
    ncyc = 0;
    while (i < nbytes && ncyc < 1000) begin
      in_byte  = blk[255 - 8*i -: 8];
      in_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (in_valid && in_ready) begin
        i++;
        nhs++;
      end
      tick;
      ncyc++;
    end
    in_valid = 1'b0;
  endtask

  // Records the button waveforms from now on while the host keeps offering junk bytes.
  task automatic measure_pulses(output int np_first, output int np_len,
                                output int st_first, output int st_len, output bit ovl);
    np_first = -1; np_len = 0; st_first = -1; st_len = 0; ovl = 1'b0;
    for (int c = 0; c < 2*BTN + 4; c++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      if (np_btn) begin
        if (np_first < 0) np_first = c;
        np_len++;
      end
      if (st_btn) begin
        if (st_first < 0) st_first = c;
        st_len++;
      end
      if (np_btn && st_btn) ovl = 1'b1;
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic fire_done(input logic [127:0] ct);
    cipher_text = ct;
    done = 1'b1;
    tick;
    done = 1'b0;
    cipher_text = rnd128();
  endtask

  task automatic receive(input int stall, output logic [127:0] got, output int nout,
                         output bit stable, output int ncyc);
    logic [7:0] b;
    got = '0; nout = 0; stable = 1'b1; ncyc = 0;
    while (nout < 16 && ncyc < 2000) begin
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'b0;
        b = out_byte;
        tick;
        ncyc++;
        if (!out_valid || out_byte !== b) stable = 1'b0;
      end
      out_ready = 1'b1;
      if (out_valid) begin
        got = {got[119:0], out_byte};
        nout++;
      end
      tick;
      ncyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #3;
    n_chk++; if ({in_ready, out_valid, np_btn, st_btn, busy, err} !== 6'b100000)
      $display("FAIL reset_ctrl got %b want 100000", {in_ready, out_valid, np_btn, st_btn, busy, err});
    else n_pass++;
    n_chk++; if (key !== '0 || plain_text !== '0)
      $display("FAIL reset_data key %h pt %h want 0", key, plain_text); else n_pass++;
    n_chk++; if (out_byte !== 8'h00) $display("FAIL reset_out_byte got %h want 00", out_byte);
    else n_pass++;
    tick; tick;
    @(negedge clk);
    rst = 1'b1;
    tick;
    n_chk++; if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release in_ready %b busy %b want 1 0", in_ready, busy); else n_pass++;
  endtask

  task automatic test_fips;
    logic [127:0] k  = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] pt = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic [127:0] got;
    int nhs, ncyc, npf, npl, stf, stl, nout;
    bit ovl, stable;
    send_bytes({k, pt}, 32, 1'b0, nhs, ncyc);
    n_chk++; if (nhs !== 32 || ncyc !== 32)
      $display("FAIL fips_in handshakes %0d cycles %0d want 32 32", nhs, ncyc); else n_pass++;
    n_chk++; if (key !== k) $display("FAIL fips_key got %h want %h", key, k); else n_pass++;
    n_chk++; if (plain_text !== pt) $display("FAIL fips_pt got %h want %h", plain_text, pt);
    else n_pass++;
    measure_pulses(npf, npl, stf, stl, ovl);
    n_chk++; if (npf !== 0 || npl !== BTN || stf !== BTN || stl !== BTN || ovl)
      $display("FAIL fips_pulses np@%0d len %0d st@%0d len %0d ovl %0b want 0 %0d %0d %0d 0",
               npf, npl, stf, stl, ovl, BTN, BTN, BTN);
    else n_pass++;
    n_chk++; if (busy !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL fips_wait busy %b out_valid %b want 1 0", busy, out_valid); else n_pass++;
    fire_done(ct);
    n_chk++; if (out_valid !== 1'b1) $display("FAIL fips_ov_latency got %b want 1", out_valid);
    else n_pass++;
    receive(0, got, nout, stable, ncyc);
    n_chk++; if (got !== ct || nout !== 16 || ncyc !== 16)
      $display("FAIL fips_out got %h n %0d cyc %0d want %h 16 16", got, nout, ncyc, ct);
    else n_pass++;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || key !== k)
      $display("FAIL fips_end out_valid %b in_ready %b key %h", out_valid, in_ready, key);
    else n_pass++;
  endtask

  task automatic test_in_backpressure;
    logic [127:0] k, pt, ct, got;
    int nhs, ncyc, npf, npl, stf, stl, nout;
    bit ovl, stable;
    for (int it = 0; it < 3; it++) begin
      k = rnd128(); pt = rnd128(); ct = rnd128();
      send_bytes({k, pt}, 32, 1'b1, nhs, ncyc);
      n_chk++; if (nhs !== 32) $display("FAIL inbp_count got %0d want 32", nhs); else n_pass++;
      measure_pulses(npf, npl, stf, stl, ovl);
      n_chk++; if (key !== k || plain_text !== pt)
        $display("FAIL inbp_data key %h pt %h want %h %h", key, plain_text, k, pt); else n_pass++;
      n_chk++; if (npf !== 0 || npl !== BTN || stf !== BTN || stl !== BTN || ovl)
        $display("FAIL inbp_pulses np@%0d len %0d st@%0d len %0d ovl %0b", npf, npl, stf, stl, ovl);
      else n_pass++;
      fire_done(ct);
      receive(0, got, nout, stable, ncyc);
      n_chk++; if (got !== ct) $display("FAIL inbp_out got %h want %h", got, ct); else n_pass++;
    end
  endtask

  task automatic test_out_backpressure;
    logic [127:0] k = rnd128(), pt = rnd128(), ct = rnd128(), got;
    int nhs, ncyc, npf, npl, stf, stl, nout;
    bit ovl, stable;
    send_bytes({k, pt}, 32, 1'b0, nhs, ncyc);
    measure_pulses(npf, npl, stf, stl, ovl);
    fire_done(ct);
    receive(5, got, nout, stable, ncyc);
    n_chk++; if (!stable) $display("FAIL outbp_stable got unstable want stable"); else n_pass++;
    n_chk++; if (got !== ct || nout !== 16)
      $display("FAIL outbp_out got %h n %0d want %h 16", got, nout, ct); else n_pass++;
    tick;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL outbp_extra out_valid %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_spurious_done;
    logic [127:0] k = rnd128(), pt = rnd128(), ct = rnd128(), got;
    int nhs, ncyc, npf, npl, stf, stl, nout;
    bit ovl, stable, seen = 1'b0;
    done = 1'b1;
    cipher_text = rnd128();
    send_bytes({k, pt}, 32, 1'b0, nhs, ncyc);
    measure_pulses(npf, npl, stf, stl, ovl);
    for (int c = 0; c < 50; c++) begin
      cipher_text = rnd128();
      if (out_valid) seen = 1'b1;
      tick;
    end
    n_chk++; if (seen || out_valid) $display("FAIL spur_capture out_valid seen %b want 0", seen);
    else n_pass++;
    done = 1'b0;
    tick;
    fire_done(ct);
    n_chk++; if (out_valid !== 1'b1) $display("FAIL spur_edge out_valid %b want 1", out_valid);
    else n_pass++;
    receive(0, got, nout, stable, ncyc);
    n_chk++; if (got !== ct) $display("FAIL spur_out got %h want %h", got, ct); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [127:0] k = rnd128(), pt = rnd128(), ct = rnd128(), got;
    int nhs, ncyc, npf, npl, stf, stl, nout;
    bit ovl, stable;
    send_bytes({rnd128(), rnd128()}, 20, 1'b0, nhs, ncyc);
    #2 rst = 1'b0;
    #1;
    n_chk++; if ({in_ready, out_valid, np_btn, st_btn, busy} !== 5'b10000 ||
                 key !== '0 || plain_text !== '0)
      $display("FAIL rstmid_load ctrl %b key %h pt %h", {in_ready, out_valid, np_btn, st_btn, busy},
               key, plain_text);
    else n_pass++;
    @(negedge clk); rst = 1'b1; tick;
    send_bytes({rnd128(), rnd128()}, 32, 1'b0, nhs, ncyc);
    n_chk++; if (np_btn !== 1'b1) $display("FAIL rstmid_np_pre got %b want 1", np_btn); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_chk++; if (np_btn !== 1'b0 || st_btn !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rstmid_pulse np %b st %b in_ready %b want 0 0 1", np_btn, st_btn, in_ready);
    else n_pass++;
    @(negedge clk); rst = 1'b1; tick;
    send_bytes({k, pt}, 32, 1'b0, nhs, ncyc);
    n_chk++; if (key !== k || plain_text !== pt)
      $display("FAIL rstmid_data key %h pt %h want %h %h", key, plain_text, k, pt); else n_pass++;
    measure_pulses(npf, npl, stf, stl, ovl);
    fire_done(ct);
    receive(0, got, nout, stable, ncyc);
    n_chk++; if (got !== ct) $display("FAIL rstmid_out got %h want %h", got, ct); else n_pass++;
  endtask

  task automatic test_timeout;
    logic [127:0] k = rnd128(), pt = rnd128(), ct = rnd128(), got;
    int nhs, ncyc, npf, npl, stf, stl, nout, n = 0;
    bit ovl, stable, seen = 1'b0;
    send_bytes({k, pt}, 32, 1'b0, nhs, ncyc);
    measure_pulses(npf, npl, stf, stl, ovl);
`ifdef AES_SEQ_TIMEOUT_EN
    // the window above already spent 4 cycles in WAIT_DONE
    while (err !== 1'b1 && n < 500) begin
      tick;
      n++;
      if (out_valid) seen = 1'b1;
    end
    n_chk++; if (n !== TMO - 4) $display("FAIL tmo_time got %0d want %0d", n, TMO - 4); else n_pass++;
    n_chk++; if (seen || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL tmo_return ov_seen %b in_ready %b busy %b", seen, in_ready, busy); else n_pass++;
    send_bytes({k, pt}, 32, 1'b0, nhs, ncyc);
    measure_pulses(npf, npl, stf, stl, ovl);
    fire_done(ct);
    receive(0, got, nout, stable, ncyc);
    n_chk++; if (got !== ct || err !== 1'b1)
      $display("FAIL tmo_sticky got %h err %b want %h 1", got, err, ct); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_chk++; if (err !== 1'b0) $display("FAIL tmo_clear err %b want 0", err); else n_pass++;
    @(negedge clk); rst = 1'b1; tick;
`else
    while (n < 200) begin
      tick;
      n++;
      if (out_valid || err) seen = 1'b1;
    end
    n_chk++; if (seen || busy !== 1'b1)
      $display("FAIL nodone_wait ov/err seen %b busy %b want 0 1", seen, busy); else n_pass++;
    fire_done(ct);
    receive(0, got, nout, stable, ncyc);
    n_chk++; if (got !== ct || err !== 1'b0)
      $display("FAIL nodone_out got %h err %b want %h 0", got, err, ct); else n_pass++;
`endif
  endtask

  initial begin
    test_reset;
    test_fips;
    test_in_backpressure;
    test_out_backpressure;
    test_spurious_done;
    test_reset_mid;
    test_timeout;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
